alu_arbiter: RTL and testbench

- Shares one combinational RV32I ALU between two requesters (REQ0 = execute-stage ALU op, REQ1 = branch/compare op).
- Arbitrates round-robin with valid/ready on each side.
- Drives the ALU's decode inputs from the granted request and registers the result/branch outcome in a one-entry output stage with backpressure.
- Sits between issue logic and the shared ALU.

---
 rtl/alu_arbiter_pkg.sv | 32 +++
 rtl/alu_arbiter_rr_arb2.sv | 35 +++
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// RV32I funct3 one-hot bit positions and the request bundle seen by the arbiter.
package alu_arbiter_pkg;

  localparam int XLEN_DEF = 32;
  localparam int TAGW_DEF = 4;

  // Bit index into the one-hot funct3 field (ALU name / branch name).
  localparam int F3_ADD_BEQ  = 0;
  localparam int F3_SLL_BNE  = 1;
  localparam int F3_SLT      = 2;
  localparam int F3_SLTU     = 3;
  localparam int F3_XOR_BLT  = 4;
  localparam int F3_SR_BGE   = 5;
  localparam int F3_OR_BLTU  = 6;
  localparam int F3_AND_BGEU = 7;

  // funct7 bit that selects SUB over ADD and SRA over SRL.
  localparam int F7_ALT = 5;

  typedef struct packed {
    logic                isALUimm;
    logic                isALUreg;
    logic                isBranch;
    logic [7:0]          funct3oh;
    logic [6:0]          funct7;
    logic [XLEN_DEF-1:0] rs1;
    logic [XLEN_DEF-1:0] rs2;
    logic [TAGW_DEF-1:0] tag;
  } req_t;

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-input round-robin grant. When both request, the one not granted last wins;
// last_grant only moves when the caller reports an accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic       grant_valid_o,
  output logic       grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant_valid_o = |req_i;
    grant_o       = 1'b0;
    case (req_i)
      2'b10:   grant_o = 1'b1;
      2'b11:   grant_o = ~last_grant_q;
      default: grant_o = 1'b0;
    endcase
    last_grant_d = accept_i ? grant_o : last_grant_q;
  end

  // Reset to 1 so requester 0 wins the first contested cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational RV32I ALU between two requesters with a registered,
// backpressured one-entry response stage. Optional counters under ALU_ARB_PERF_EN.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_isALUimm,
  input  logic [1:0]        req_isALUreg,
  input  logic [1:0]        req_isBranch,
  input  logic [15:0]       req_funct3oh,
  input  logic [13:0]       req_funct7,
  input  logic [2*XLEN-1:0] req_rs1,
  input  logic [2*XLEN-1:0] req_rs2,
  input  logic [2*TAGW-1:0] req_tag,
  output logic              alu_isALUimm,
  output logic              alu_isALUreg,
  output logic              alu_isBranch,
  output logic [7:0]        alu_funct3oh,
  output logic [6:0]        alu_funct7,
  output logic [XLEN-1:0]   alu_rs1,
  output logic [XLEN-1:0]   alu_rs2,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_correct,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [TAGW-1:0]   rsp_tag,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_correct
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_stall
`endif
);

  req_t req [2];
  req_t sel;
  logic grant_valid;
  logic grant;
  logic can_accept;
  logic accept;

  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [TAGW-1:0] rsp_tag_q;
  logic [XLEN-1:0] rsp_result_q;
  logic            rsp_correct_q;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req[i]          = '0;
      req[i].isALUimm = req_isALUimm[i];
      req[i].isALUreg = req_isALUreg[i];
      req[i].isBranch = req_isBranch[i];
      req[i].funct3oh = req_funct3oh[8*i +: 8];
      req[i].funct7   = req_funct7[7*i +: 7];
      req[i].rs1      = req_rs1[XLEN*i +: XLEN];
      req[i].rs2      = req_rs2[XLEN*i +: XLEN];
      req[i].tag      = req_tag[TAGW*i +: TAGW];
    end
  end

  rr_arb2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_valid),
    .accept_i     (accept),
    .grant_valid_o(grant_valid),
    .grant_o      (grant)
  );

  // Handshake: req_valid[i] & req_ready[i] on a rising edge transfers request i.
  // rsp_valid & rsp_ready on a rising edge consumes the response entry.
  assign can_accept = ~rsp_valid_q | rsp_ready;
  assign accept     = grant_valid & can_accept;

  always_comb begin
    req_ready = 2'b00;
    if (accept) req_ready[grant] = 1'b1;
  end

  // The ALU sees the granted request even while stalled; with no grant it idles on zeros.
  always_comb begin
    sel = '0;
    if (grant_valid) sel = req[grant];
  end

  assign alu_isALUimm = sel.isALUimm;
  assign alu_isALUreg = sel.isALUreg;
  assign alu_isBranch = sel.isBranch;
  assign alu_funct3oh = sel.funct3oh;
  assign alu_funct7   = sel.funct7;
  assign alu_rs1      = sel.rs1;
  assign alu_rs2      = sel.rs2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_result_q  <= '0;
      rsp_correct_q <= 1'b0;
    end else if (accept) begin
      rsp_valid_q   <= 1'b1;
      rsp_id_q      <= grant;
      rsp_tag_q     <= sel.tag;
      rsp_result_q  <= alu_result;
      rsp_correct_q <= alu_correct;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_q   <= 1'b0;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_correct = rsp_correct_q;

`ifdef ALU_ARB_PERF_EN
  logic [31:0] perf_grant0_q;
  logic [31:0] perf_grant1_q;
  logic [31:0] perf_stall_q;

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grant0_q <= '0;
      perf_grant1_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if (accept && !grant) perf_grant0_q <= perf_grant0_q + 32'd1;
      if (accept && grant)  perf_grant1_q <= perf_grant1_q + 32'd1;
      if ((|req_valid) && !can_accept) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_grant0 = perf_grant0_q;
  assign perf_grant1 = perf_grant1_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, scoreboard of expected
// responses from an operation-level reference model. ALU_ARB_PERF_EN adds counter checks.
module tb_alu_arbiter;

  localparam int XLEN = 32;
  localparam int TAGW = 4;
  localparam int EW   = 1 + TAGW + XLEN + 1;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU, OP_NOP
  } op_e;

  typedef struct packed {
    op_e         op;
    logic        imm;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
  } txn_t;

  typedef struct packed {
    logic       isimm;
    logic       isreg;
    logic       isbr;
    logic [7:0] f3oh;
    logic [6:0] f7;
  } dec_t;

  logic              clk;
  logic              rst_n;
  logic [1:0]        req_valid, req_ready, req_isALUimm, req_isALUreg, req_isBranch;
  logic [15:0]       req_funct3oh;
  logic [13:0]       req_funct7;
  logic [2*XLEN-1:0] req_rs1, req_rs2;
  logic [2*TAGW-1:0] req_tag;
  logic              alu_isALUimm, alu_isALUreg, alu_isBranch;
  logic [7:0]        alu_funct3oh;
  logic [6:0]        alu_funct7;
  logic [XLEN-1:0]   alu_rs1, alu_rs2, alu_result;
  logic              alu_correct;
  logic              rsp_valid, rsp_ready, rsp_id;
  logic [TAGW-1:0]   rsp_tag;
  logic [XLEN-1:0]   rsp_result;
  logic              rsp_correct;
`ifdef ALU_ARB_PERF_EN
  logic [31:0]       perf_grant0, perf_grant1, perf_stall;
`endif

  alu_arbiter #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_isALUimm(req_isALUimm), .req_isALUreg(req_isALUreg), .req_isBranch(req_isBranch),
    .req_funct3oh(req_funct3oh), .req_funct7(req_funct7),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .alu_isALUimm(alu_isALUimm), .alu_isALUreg(alu_isALUreg), .alu_isBranch(alu_isBranch),
    .alu_funct3oh(alu_funct3oh), .alu_funct7(alu_funct7),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_result(alu_result), .alu_correct(alu_correct),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result), .rsp_correct(rsp_correct)
`ifdef ALU_ARB_PERF_EN
    , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
  );

  // Shared RV32I ALU attached to the arbiter, decoding the one-hot funct3 fields.
  always_comb begin
    alu_result  = '0;
    alu_correct = 1'b0;
    if (alu_isALUreg || alu_isALUimm) begin
      if (alu_funct3oh[0]) alu_result = (alu_isALUreg && alu_funct7[5]) ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
      if (alu_funct3oh[1]) alu_result = alu_rs1 << alu_rs2[4:0];
      if (alu_funct3oh[2]) alu_result = {31'b0, $signed(alu_rs1) < $signed(alu_rs2)};
      if (alu_funct3oh[3]) alu_result = {31'b0, alu_rs1 < alu_rs2};
      if (alu_funct3oh[4]) alu_result = alu_rs1 ^ alu_rs2;
      if (alu_funct3oh[5]) alu_result = alu_funct7[5] ? $unsigned($signed(alu_rs1) >>> alu_rs2[4:0])
                                                      : alu_rs1 >> alu_rs2[4:0];
      if (alu_funct3oh[6]) alu_result = alu_rs1 | alu_rs2;
      if (alu_funct3oh[7]) alu_result = alu_rs1 & alu_rs2;
    end
    if (alu_isBranch) begin
      if (alu_funct3oh[0]) alu_correct = (alu_rs1 == alu_rs2);
      if (alu_funct3oh[1]) alu_correct = (alu_rs1 != alu_rs2);
      if (alu_funct3oh[4]) alu_correct = ($signed(alu_rs1) < $signed(alu_rs2));
      if (alu_funct3oh[5]) alu_correct = ($signed(alu_rs1) >= $signed(alu_rs2));
      if (alu_funct3oh[6]) alu_correct = (alu_rs1 < alu_rs2);
      if (alu_funct3oh[7]) alu_correct = (alu_rs1 >= alu_rs2);
    end
  end

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bench state ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [EW-1:0] exp_q[$];
  txn_t          slot [2];
  logic          slot_busy [2];
  logic          m_rsp_valid;
  logic          m_last;
  logic          snap_v;
  logic [EW-1:0] snap;
  logic [3:0]    next_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic dec_t encode(input txn_t t);
    dec_t d;
    int   f3;
    d  = '0;
    f3 = 0;
    case (t.op)
      OP_SLL, OP_BNE:  f3 = 1;
      OP_SLT:          f3 = 2;
      OP_SLTU:         f3 = 3;
      OP_XOR, OP_BLT:  f3 = 4;
      OP_SRL, OP_SRA, OP_BGE: f3 = 5;
      OP_OR, OP_BLTU:  f3 = 6;
      OP_AND, OP_BGEU: f3 = 7;
      default:         f3 = 0;
    endcase
    if (t.op == OP_SUB || t.op == OP_SRA) d.f7 = 7'h20;
    d.f3oh = 8'(1 << f3);
    if (t.op == OP_NOP) begin
      d.isimm = 1'b0;
    end else if (t.op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU}) begin
      d.isbr = 1'b1;
    end else if (t.imm && t.op != OP_SUB) begin
      d.isimm = 1'b1;
    end else begin
      d.isreg = 1'b1;
    end
    return d;
  endfunction

  function automatic logic [31:0] ref_result(input txn_t t);
    int unsigned        sh;
    logic signed [31:0] sa, sb;
    sh = t.b % 32;
    sa = t.a;
    sb = t.b;
    case (t.op)
      OP_ADD:  return t.a + t.b;
      OP_SUB:  return t.a - t.b;
      OP_SLL:  return t.a << sh;
      OP_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
      OP_SLTU: return (t.a < t.b) ? 32'd1 : 32'd0;
      OP_XOR:  return t.a ^ t.b;
      OP_SRL:  return t.a >> sh;
      OP_SRA:  return sa >>> sh;
      OP_OR:   return t.a | t.b;
      OP_AND:  return t.a & t.b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_correct(input txn_t t);
    logic signed [31:0] sa, sb;
    sa = t.a;
    sb = t.b;
    case (t.op)
      OP_BEQ:  return t.a == t.b;
      OP_BNE:  return t.a != t.b;
      OP_BLT:  return sa < sb;
      OP_BGE:  return sa >= sb;
      OP_BLTU: return t.a < t.b;
      OP_BGEU: return t.a >= t.b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic txn_t mk(input op_e op, input logic [31:0] a, input logic [31:0] b,
                              input logic [3:0] tag);
    txn_t t;
    t.op = op; t.imm = 1'b0; t.a = a; t.b = b; t.tag = tag;
    return t;
  endfunction

  function automatic txn_t rand_txn(input logic [3:0] tag);
    txn_t t;
    t.op  = op_e'($urandom_range(0, 16));
    t.imm = 1'($urandom_range(0, 1));
    t.a   = $urandom;
    t.b   = ($urandom_range(0, 3) == 0) ? t.a : $urandom;
    if ($urandom_range(0, 2) == 0) t.b = $urandom_range(0, 40);
    t.tag = tag;
    return t;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_inputs();
    dec_t d;
    for (int i = 0; i < 2; i++) begin
      if (slot_busy[i]) begin
        d = encode(slot[i]);
        req_valid[i]          = 1'b1;
        req_isALUimm[i]       = d.isimm;
        req_isALUreg[i]       = d.isreg;
        req_isBranch[i]       = d.isbr;
        req_funct3oh[8*i +: 8] = d.f3oh;
        req_funct7[7*i +: 7]  = d.f7;
        req_rs1[32*i +: 32]   = slot[i].a;
        req_rs2[32*i +: 32]   = slot[i].b;
        req_tag[4*i +: 4]     = slot[i].tag;
      end else begin
        req_valid[i]          = 1'b0;
        req_isALUimm[i]       = 1'($urandom_range(0, 1));
        req_isALUreg[i]       = 1'($urandom_range(0, 1));
        req_isBranch[i]       = 1'($urandom_range(0, 1));
        req_funct3oh[8*i +: 8] = 8'($urandom);
        req_funct7[7*i +: 7]  = 7'($urandom);
        req_rs1[32*i +: 32]   = $urandom;
        req_rs2[32*i +: 32]   = $urandom;
        req_tag[4*i +: 4]     = 4'($urandom);
      end
    end
  endtask

  task automatic load(input int i, input txn_t t);
    slot[i]      = t;
    slot_busy[i] = 1'b1;
  endtask

  // Checks one cycle at the falling edge, then advances the model across the rising edge.
  task automatic run_cycle();
    logic          can_acc, have_g, g;
    logic [1:0]    exp_ready;
    dec_t          d;
    logic [EW-1:0] cur;
    @(negedge clk);
    can_acc   = !m_rsp_valid || rsp_ready;
    have_g    = |req_valid;
    g         = (req_valid == 2'b11) ? !m_last : req_valid[1];
    exp_ready = (have_g && can_acc) ? (g ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
    if (have_g) begin
      d = encode(slot[g]);
      chk("alu_dec", 64'({alu_isALUimm, alu_isALUreg, alu_isBranch, alu_funct3oh, alu_funct7}), 64'(d));
      chk("alu_ops", {alu_rs1, alu_rs2}, {slot[g].a, slot[g].b});
    end else begin
      chk("alu_idle_dec", 64'({alu_isALUimm, alu_isALUreg, alu_isBranch, alu_funct3oh, alu_funct7}), 64'd0);
      chk("alu_idle_ops", {alu_rs1, alu_rs2}, 64'd0);
    end
    cur = {rsp_id, rsp_tag, rsp_result, rsp_correct};
    if (snap_v) chk("rsp_hold", 64'(cur), 64'(snap));
    snap_v = m_rsp_valid && !rsp_ready;
    snap   = cur;
    if (have_g && can_acc) begin
      exp_q.push_back({g, slot[g].tag, ref_result(slot[g]), ref_correct(slot[g])});
      m_last       = g;
      slot_busy[g] = 1'b0;
      m_rsp_valid  = 1'b1;
    end else if (m_rsp_valid && rsp_ready) begin
      m_rsp_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    for (int k = 0; k < 8 && (m_rsp_valid || slot_busy[0] || slot_busy[1]); k++) begin
      apply_inputs();
      run_cycle();
    end
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // Called just after a rising edge: asserts reset between edges and restarts the model.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_rsp", 64'({rsp_id, rsp_tag, rsp_result, rsp_correct}), 64'd0);
    exp_q.delete();
    m_rsp_valid  = 1'b0;
    m_last       = 1'b1;
    snap_v       = 1'b0;
    slot_busy[0] = 1'b0;
    slot_busy[1] = 1'b0;
    apply_inputs();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence + monitor ----------------
  initial begin
    rst_n        = 1'b0;
    rsp_ready    = 1'b0;
    m_rsp_valid  = 1'b0;
    m_last       = 1'b1;
    snap_v       = 1'b0;
    snap         = '0;
    next_tag     = 4'd0;
    slot_busy[0] = 1'b0;
    slot_busy[1] = 1'b0;
    slot[0]      = '0;
    slot[1]      = '0;
    apply_inputs();

    fork
      forever begin
        @(negedge clk);
        if (rst_n && rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
          else chk("rsp", 64'({rsp_id, rsp_tag, rsp_result, rsp_correct}), 64'(exp_q.pop_front()));
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
      end
    join_none

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp", 64'({rsp_id, rsp_tag, rsp_result, rsp_correct}), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single ADD from requester 0.
    rsp_ready = 1'b1;
    load(0, mk(OP_ADD, 32'd5, 32'd7, 4'd3));
    apply_inputs();
    run_cycle();
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_tag", 64'(rsp_tag), 64'd3);
    chk("t1_result", 64'(rsp_result), 64'd12);

    // Both requesters always valid: grants alternate.
    for (int k = 0; k < 8; k++) begin
      if (!slot_busy[0]) begin load(0, mk(OP_SUB, 32'd10, 32'd3, next_tag)); next_tag++; end
      if (!slot_busy[1]) begin load(1, mk(OP_XOR, 32'hF0, 32'h0F, next_tag)); next_tag++; end
      apply_inputs();
      run_cycle();
      chk("t2_result", 64'(rsp_result), rsp_id ? 64'hFF : 64'd7);
    end
    drain();

    // BEQ held under backpressure, then drain and accept in the same cycle.
    load(1, mk(OP_BEQ, 32'h1234, 32'h1234, 4'd5));
    apply_inputs();
    run_cycle();
    load(0, mk(OP_ADD, 32'd1, 32'd2, 4'd6));
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      apply_inputs();
      #1 chk("t3_stall_ready", 64'(req_ready), 64'd0);
      chk("t3_correct", 64'(rsp_correct), 64'd1);
      run_cycle();
    end
    rsp_ready = 1'b1;
    apply_inputs();
    run_cycle();
    chk("t3_next_id", 64'(rsp_id), 64'd0);
    chk("t3_next_result", 64'(rsp_result), 64'd3);
    drain();

    // SRA then SLTU back to back.
    load(0, mk(OP_SRA, 32'h8000_0000, 32'd4, 4'd7));
    apply_inputs();
    run_cycle();
    load(0, mk(OP_SLTU, 32'd1, 32'd2, 4'd8));
    apply_inputs();
    chk("t4_sra", 64'(rsp_result), 64'hF800_0000);
    run_cycle();
    chk("t4_sltu", 64'(rsp_result), 64'd1);
    chk("t4_valid", 64'(rsp_valid), 64'd1);
    drain();

    // Reset with a response pending; requester 0 must win afterwards.
    rsp_ready = 1'b0;
    load(1, mk(OP_OR, 32'h0F00, 32'h00F0, 4'd9));
    apply_inputs();
    run_cycle();
    async_reset();
    rsp_ready = 1'b1;
    load(0, mk(OP_AND, 32'hFF00, 32'h0FF0, 4'd10));
    load(1, mk(OP_SLL, 32'd1, 32'd31, 4'd11));
    apply_inputs();
    #1 chk("t5_rr_after_reset", 64'(req_ready), 64'd1);
    run_cycle();
    drain();

    // Random traffic with random backpressure.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!slot_busy[i] && $urandom_range(0, 99) < 60) begin
          load(i, rand_txn(next_tag));
          next_tag++;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      apply_inputs();
      run_cycle();
    end
    drain();

`ifdef ALU_ARB_PERF_EN
    // 10 requester-0 ops, 6 requester-1 ops and 4 stall cycles since reset.
    async_reset();
    rsp_ready = 1'b1;
    load(0, mk(OP_ADD, 32'd1, 32'd1, next_tag)); next_tag++;
    apply_inputs();
    run_cycle();
    load(0, mk(OP_ADD, 32'd2, 32'd2, next_tag)); next_tag++;
    rsp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      apply_inputs();
      run_cycle();
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (!slot_busy[0]) begin load(0, mk(OP_XOR, 32'd3, 32'd5, next_tag)); next_tag++; end
      apply_inputs();
      run_cycle();
    end
    for (int k = 0; k < 12; k++) begin
      if (!slot_busy[0]) begin load(0, mk(OP_SUB, 32'd9, 32'd4, next_tag)); next_tag++; end
      if (!slot_busy[1]) begin load(1, mk(OP_BNE, 32'd9, 32'd4, next_tag)); next_tag++; end
      apply_inputs();
      run_cycle();
    end
    chk("perf_grant0", 64'(perf_grant0), 64'd10);
    chk("perf_grant1", 64'(perf_grant1), 64'd6);
    chk("perf_stall", 64'(perf_stall), 64'd4);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
